// File: rtl/crank_decoder.sv
// crank_decoder: missing-tooth crank wheel decoder producing tooth strobe, index, period and sync/stall status.
// Define CRANK_DECODER_ERRCNT_EN to build the saturating sync-loss counter on sync_err_cnt.
module crank_decoder #(
  parameter int TEETH = 60,
  parameter int MISSING = 2,
  parameter int FILT = 4,
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vrin,
  output logic                tooth_strobe,
  output logic [5:0]          tooth_num,
  output logic [PERIOD_W-1:0] tooth_period,
  output logic                synced,
  output logic                stalled,
  output logic [7:0]          sync_err_cnt
);
  localparam int FW = $clog2(FILT) + 1;
  localparam logic [FW-1:0] FLIM = FW'(FILT - 1);
  localparam logic [5:0] LAST = 6'(TEETH - MISSING - 1);
  typedef enum logic [1:0] {IDLE, FIRST, HUNT, SYNCED} state_t;
  state_t state, state_d;
  logic s1, s2, filt, flip, edge_ev, sat, stall_ev, gap;
  logic [FW-1:0] fcnt;
  logic [PERIOD_W-1:0] per_cnt, new_period;
  logic [PERIOD_W+1:0] two_new, three_old;
  logic [5:0] num_d;
  assign flip = (s2 != filt) && (fcnt == FLIM);
  assign edge_ev = flip && s2;
  assign sat = &per_cnt;
  assign stall_ev = sat && !edge_ev;
  // Counter is cleared on the edge cycle, so the interval in cycles is the count plus one.
  assign new_period = sat ? per_cnt : per_cnt + 1'b1;
  assign two_new = {1'b0, new_period, 1'b0};
  assign three_old = {2'b00, tooth_period} + {1'b0, tooth_period, 1'b0};
  assign gap = (state == HUNT || state == SYNCED) && two_new > three_old;
  assign synced = state == SYNCED;
  always_ff @(posedge clk)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      filt <= 1'b0;
      fcnt <= '0;
      per_cnt <= '0;
      tooth_period <= '0;
      stalled <= 1'b1;
      tooth_strobe <= 1'b0;
      state <= IDLE;
      tooth_num <= '0;
    end else begin
      s1 <= vrin;
      s2 <= s1;
      fcnt <= (s2 != filt && !flip) ? fcnt + 1'b1 : '0;
      if (flip) filt <= s2;
      per_cnt <= edge_ev ? '0 : sat ? per_cnt : per_cnt + 1'b1;
      tooth_period <= edge_ev ? new_period : stall_ev ? '0 : tooth_period;
      stalled <= edge_ev ? 1'b0 : stall_ev ? 1'b1 : stalled;
      tooth_strobe <= edge_ev;
      state <= state_d;
      tooth_num <= num_d;
    end
  always_comb begin
    state_d = state;
    num_d = tooth_num;
    if (stall_ev) begin
      state_d = IDLE;
      num_d = '0;
    end else if (edge_ev)
      case (state)
        IDLE: state_d = FIRST;
        FIRST: state_d = HUNT;
        HUNT: begin
          state_d = gap ? SYNCED : HUNT;
          num_d = '0;
        end
        default:
          if (gap == (tooth_num == LAST)) num_d = gap ? '0 : tooth_num + 6'd1;
          else begin
            state_d = HUNT;
            num_d = '0;
          end
      endcase
  end
`ifdef CRANK_DECODER_ERRCNT_EN
  logic err_inc;
  assign err_inc = state == SYNCED && (stall_ev || (edge_ev && gap != (tooth_num == LAST)));
  always_ff @(posedge clk)
    if (reset) sync_err_cnt <= '0;
    else if (err_inc && !(&sync_err_cnt)) sync_err_cnt <= sync_err_cnt + 8'd1;
`else
  assign sync_err_cnt = '0;
`endif
endmodule

// File: tb/tb_crank_decoder.sv
// tb_crank_decoder: random-jitter 60-2 wheel stimulus checked against a tooth-level reference model.
module tb_crank_decoder;
  localparam int TEETH = 60;
  localparam int MISSING = 2;
  localparam int FILT = 4;
  localparam int PW = 12;
  localparam int PHYS = TEETH - MISSING;
  localparam int HI = 20;
  logic clk = 1'b0, reset = 1'b1, vrin = 1'b0;
  logic tooth_strobe, synced, stalled;
  logic [5:0] tooth_num;
  logic [PW-1:0] tooth_period;
  logic [7:0] sync_err_cnt;
  int total = 0, bad = 0;
  int mdl_edges, mdl_prev, mdl_num, mdl_err, wpos;
  bit mdl_synced;

  crank_decoder #(.TEETH(TEETH), .MISSING(MISSING), .FILT(FILT), .PERIOD_W(PW)) dut (
    .clk(clk), .reset(reset), .vrin(vrin), .tooth_strobe(tooth_strobe), .tooth_num(tooth_num),
    .tooth_period(tooth_period), .synced(synced), .stalled(stalled), .sync_err_cnt(sync_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_err();
`ifdef CRANK_DECODER_ERRCNT_EN
    return mdl_err > 255 ? 255 : mdl_err;
`else
    return 0;
`endif
  endfunction

  // Reference: position is known only after a gap is seen, and must then see a gap exactly every PHYS teeth.
  task automatic mdl_edge(input int p);
    bit g;
    g = mdl_edges >= 2 && 2 * p > 3 * mdl_prev;
    if (mdl_synced) begin
      if (g == (mdl_num == PHYS - 1)) mdl_num = g ? 0 : mdl_num + 1;
      else begin
        mdl_synced = 0;
        mdl_num = 0;
        mdl_err++;
      end
    end else if (g) begin
      mdl_synced = 1;
      mdl_num = 0;
    end
    mdl_edges++;
    mdl_prev = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    vrin = 1'b0;
    @(negedge clk);
    chk("rst_strobe", tooth_strobe, 0);
    chk("rst_num", tooth_num, 0);
    chk("rst_period", tooth_period, 0);
    chk("rst_synced", synced, 0);
    chk("rst_stalled", stalled, 1);
    chk("rst_err", sync_err_cnt, 0);
    reset = 1'b0;
    mdl_edges = 0;
    mdl_synced = 0;
    mdl_num = 0;
    mdl_err = 0;
  endtask

  // One tooth: rising edge lands p cycles after the previous tooth's rising edge.
  task automatic tooth(input int p, input bit glitch);
    int cnt, gs, gl;
    cnt = 0;
    gs = p / 3 + int'($urandom_range(0, 5));
    gl = int'($urandom_range(1, FILT - 1));
    mdl_edge(p);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (tooth_strobe) begin
        cnt++;
        chk("num", tooth_num, mdl_num);
        chk("synced", synced, mdl_synced);
        chk("stalled", stalled, 0);
        chk("err", sync_err_cnt, exp_err());
        if (mdl_edges >= 2) chk("period", tooth_period, p);
      end
      vrin = (i >= p - HI) || (glitch && i >= gs && i < gs + gl);
    end
    chk("strobes", cnt, 1);
    chk("hold", tooth_num, mdl_num);
  endtask

  task automatic run(input int n, input int t, input bit glitchy);
    int p;
    for (int k = 0; k < n; k++) begin
      p = (wpos == 0 ? (MISSING + 1) * t : t) + int'($urandom_range(0, 4)) - 2;
      tooth(p, glitchy && $urandom_range(0, 2) == 0);
      wpos = (wpos + 1) % PHYS;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vrin = 1'b0;
    end
    if (mdl_synced) mdl_err++;
    mdl_synced = 0;
    mdl_num = 0;
    mdl_edges = 0;
    chk("stall_flag", stalled, 1);
    chk("stall_synced", synced, 0);
    chk("stall_num", tooth_num, 0);
    chk("stall_err", sync_err_cnt, exp_err());
  endtask

  initial begin
    do_reset();
    wpos = int'($urandom_range(0, PHYS - 1));
    run(150, 80, 1);
    chk("sync_first", synced, 1);
    run(60, 76, 0);
    run(60, 72, 0);
    chk("sync_accel", synced, 1);
    while (wpos != 20) run(1, 80, 0);
    tooth(160, 0);
    wpos = 22;
    chk("drop_synced", synced, 0);
    chk("drop_err", sync_err_cnt, exp_err());
    run(70, 80, 1);
    chk("resync_drop", synced, 1);
    idle(5000);
    run(70, 80, 0);
    chk("resync_stall", synced, 1);
    while (wpos != 30) run(1, 80, 0);
    do_reset();
    run(2, 80, 0);
    chk("post_rst_synced", synced, 0);
    run(70, 80, 0);
    chk("resync_rst", synced, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
